// File: rtl/dot_write_scheduler.sv
// Queues processor MMIO writes to the dot window and drains them to the VGA dot store during blanking.
// Optional DOT_SCHED_STATS_EN adds drop_count and max_count statistics outputs.
module dot_write_scheduler #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DOT_BASE  = 100,
  parameter int unsigned Y_BASE    = 550,
  parameter int unsigned DOT_TOP   = 999,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wren,
  input  logic [31:0]              address_dmem,
  input  logic [31:0]              data,
  input  logic                     blank,
  output logic                     dot_wren,
  output logic                     dot_is_y,
  output logic [9:0]               dot_id,
  output logic [31:0]              dot_loc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef DOT_SCHED_STATS_EN
  ,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   max_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic        is_y;
    logic [9:0]  id;
    logic [31:0] loc;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [BW-1:0] r_burst;

  logic          w_hit;
  logic          w_is_y;
  logic [9:0]    w_id;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  entry_t        w_head;

  // Address decode of the dot window
  assign w_hit  = wren && (address_dmem >= 32'(DOT_BASE)) && (address_dmem <= 32'(DOT_TOP));
  assign w_is_y = address_dmem >= 32'(Y_BASE);
  assign w_id   = 10'(address_dmem - (w_is_y ? 32'(Y_BASE) : 32'(DOT_BASE)));

  assign w_full      = r_count == CW'(DEPTH);
  assign w_push      = w_hit && (!w_full || w_pop);
  assign w_drop      = w_hit && w_full && !w_pop;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (blank && r_count != '0) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!w_pop) begin
          if (!blank)                           w_state_nxt = S_IDLE;
          else if (r_burst == BW'(MAX_BURST))   w_state_nxt = S_HOLD;
        end
      end
      S_HOLD:  if (!blank) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop = 1'b0;
    if (r_state == S_DRAIN && blank && r_count != '0 && r_burst < BW'(MAX_BURST))
      w_pop = 1'b1;
  end

  // Storage carries no reset; only pointers and count define validity
  always_ff @(posedge clock) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= '{is_y: w_is_y, id: w_id, loc: data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_burst  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      if (r_state == S_IDLE) r_burst <= '0;
      else if (w_pop)        r_burst <= r_burst + BW'(1);
      if (w_drop) overflow <= 1'b1;
    end
  end

  // Registered dot update port; payload holds between pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      dot_wren <= 1'b0;
      dot_is_y <= 1'b0;
      dot_id   <= '0;
      dot_loc  <= '0;
    end else begin
      dot_wren <= w_pop;
      if (w_pop) begin
        dot_is_y <= w_head.is_y;
        dot_id   <= w_head.id;
        dot_loc  <= w_head.loc;
      end
    end
  end

  assign fifo_count = r_count;

`ifdef DOT_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
      max_count  <= '0;
    end else begin
      if (w_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (w_count_nxt > max_count) max_count <= w_count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_dot_write_scheduler.sv
// Scoreboard bench for dot_write_scheduler: expected dot updates queued at stimulus, checked by a monitor.
module tb_dot_write_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        blank;
  logic        dot_wren;
  logic        dot_is_y;
  logic [9:0]  dot_id;
  logic [31:0] dot_loc;
  logic [4:0]  fifo_count;
  logic        overflow;
`ifdef DOT_SCHED_STATS_EN
  logic [15:0] drop_count;
  logic [4:0]  max_count;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [42:0] exp_q[$];
  int          pulse_q[$];

  dot_write_scheduler dut (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
    .data(data), .blank(blank), .dot_wren(dot_wren), .dot_is_y(dot_is_y),
    .dot_id(dot_id), .dot_loc(dot_loc), .fifo_count(fifo_count), .overflow(overflow)
`ifdef DOT_SCHED_STATS_EN
    , .drop_count(drop_count), .max_count(max_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // Monitor: every dot_wren pulse must match the head of the expected queue
  always @(negedge clock) begin
    if (dot_wren === 1'b1) begin
      pulse_q.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got id=%0d loc=%0d expected no pulse", dot_id, dot_loc);
      end else begin
        logic [42:0] e;
        e = exp_q.pop_front();
        if ({dot_is_y, dot_id, dot_loc} === e) passed++;
        else $display("FAIL dot_entry: got y=%0d id=%0d loc=%0d expected y=%0d id=%0d loc=%0d",
                      dot_is_y, dot_id, dot_loc, e[42], e[41:32], e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wren = 1'b1; address_dmem = a; data = d;
    step();
    wren = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; wren = 1'b0; address_dmem = '0; data = '0; blank = 1'b0;
    #1;
    do_reset();
    chk("rst_dot_wren", dot_wren, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dot_payload", {dot_is_y, dot_id, dot_loc}, 0);

    // Single X write during blanking: pulse two edges after push
    blank = 1'b1;
    pulse_q.delete();
    exp_q.push_back({1'b0, 10'd5, 32'd320});
    wr(32'd105, 32'd320);
    n = cyc;
    chk("x_count_after_push", fifo_count, 1);
    repeat (4) step();
    chk("x_pulses", pulse_q.size(), 1);
    chk("x_latency", (pulse_q.size() > 0) ? pulse_q[0] : -1, n + 2);
    chk("x_count_drained", fifo_count, 0);

    // Y write held off while not blanking
    blank = 1'b0;
    pulse_q.delete();
    exp_q.push_back({1'b1, 10'd10, 32'd240});
    wr(32'd560, 32'd240);
    repeat (20) step();
    chk("y_no_pulse_active", pulse_q.size(), 0);
    chk("y_count_waiting", fifo_count, 1);
    blank = 1'b1;
    repeat (4) step();
    chk("y_pulse_after_blank", pulse_q.size(), 1);
    chk("y_count_drained", fifo_count, 0);

    // Non-hit writes
    pulse_q.delete();
    wr(32'd99, 32'd1);   chk("nohit_99", fifo_count, 0);
    wr(32'd1000, 32'd2); chk("nohit_1000", fifo_count, 0);
    wr(32'd50, 32'd3);   chk("nohit_50", fifo_count, 0);
    address_dmem = 32'd200; data = 32'd4; wren = 1'b0;
    step();              chk("nohit_wren0", fifo_count, 0);
    repeat (3) step();
    chk("nohit_no_pulse", pulse_q.size(), 0);

    // 17 writes into a 16-deep queue while not blanking
    blank = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back({1'b0, 10'(i), 32'(1000 + i)});
      wr(32'(100 + i), 32'(1000 + i));
    end
    chk("ovf_count_full", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
`ifdef DOT_SCHED_STATS_EN
    chk("ovf_drop_count", drop_count, 1);
    chk("ovf_max_count", max_count, 16);
`endif
    pulse_q.delete();
    blank = 1'b1;
    repeat (30) step();
    chk("ovf_burst_pulses", pulse_q.size(), 8);
    chk("ovf_burst_consecutive", (pulse_q.size() == 8) ? pulse_q[7] - pulse_q[0] : -1, 7);
    chk("ovf_count_after_burst", fifo_count, 8);
    blank = 1'b0;
    repeat (3) step();
    blank = 1'b1;
    repeat (15) step();
    chk("ovf_all_pulses", pulse_q.size(), 16);
    chk("ovf_count_empty", fifo_count, 0);
    chk("ovf_17th_absent", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);

    // 12 queued, burst cap then remainder next interval
    do_reset();
    chk("rst_clears_overflow", overflow, 0);
    blank = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({1'b1, 10'(i), 32'(7 * i)});
      wr(32'(550 + i), 32'(7 * i));
    end
    chk("b12_count", fifo_count, 12);
    pulse_q.delete();
    blank = 1'b1;
    repeat (30) step();
    chk("b12_burst_pulses", pulse_q.size(), 8);
    chk("b12_consecutive", (pulse_q.size() == 8) ? pulse_q[7] - pulse_q[0] : -1, 7);
    chk("b12_count_hold", fifo_count, 4);
    blank = 1'b0;
    repeat (2) step();
    blank = 1'b1;
    repeat (10) step();
    chk("b12_total_pulses", pulse_q.size(), 12);
    chk("b12_count_empty", fifo_count, 0);

    // Full queue: push coincident with pop, then reset mid-burst
    do_reset();
    blank = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'b0, 10'(200 + i), 32'(i)});
      wr(32'(300 + i), 32'(i));
    end
    chk("full_count", fifo_count, 16);
    blank = 1'b1;
    step();
    exp_q.push_back({1'b1, 10'd449, 32'hDEAD_BEEF});
    wr(32'd999, 32'hDEAD_BEEF);
    chk("pushpop_count", fifo_count, 16);
    chk("pushpop_no_overflow", overflow, 0);
    step(); step();
    reset = 1'b1;
    step();
    chk("midrst_dot_wren", dot_wren, 0);
    chk("midrst_count", fifo_count, 0);
    reset = 1'b0;
    exp_q.delete();
    pulse_q.delete();
    repeat (5) step();
    chk("midrst_no_pulse", pulse_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
